// File: rtl/div_ctrl_if.sv
// Handshake and data bundle between the EX stage and the divide controller.
interface div_ctrl_if;
    logic        start_i;
    logic        signed_i;
    logic [31:0] oprand1_i;
    logic [31:0] oprand2_i;
    logic        cancel_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        pauseRequest_o;

    modport master (
        output start_i, signed_i, oprand1_i, oprand2_i, cancel_i,
        input  result_o, ready_o, pauseRequest_o
    );

    modport slave (
        input  start_i, signed_i, oprand1_i, oprand2_i, cancel_i,
        output result_o, ready_o, pauseRequest_o
    );
endinterface

// File: rtl/div_ctrl.sv
// 32-bit signed/unsigned restoring divider, one quotient bit per cycle.
// Result is {remainder, quotient}, presented for one cycle with ready_o.
module div_ctrl (
    input  logic       clk,
    input  logic       rst,
    div_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_DIVZERO = 2'b01,
        S_ON      = 2'b10,
        S_END     = 2'b11
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic [32:0] trial;
    logic [32:0] diff;
    logic [31:0] rem_n;
    logic [31:0] quo_n;
    logic        accept;

    assign accept = bus.start_i && !bus.cancel_i;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = '0;
        ready_d  = 1'b0;

        // Shift the next dividend bit into the partial remainder; a clear
        // borrow bit means the divisor fits.
        trial = {rem_q, quo_q[31]};
        diff  = trial - {1'b0, dvs_q};
        if (!diff[32]) begin
            rem_n = diff[31:0];
            quo_n = {quo_q[30:0], 1'b1};
        end else begin
            rem_n = trial[31:0];
            quo_n = {quo_q[30:0], 1'b0};
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    quo_d  = (bus.signed_i && bus.oprand1_i[31]) ? -bus.oprand1_i : bus.oprand1_i;
                    dvs_d  = (bus.signed_i && bus.oprand2_i[31]) ? -bus.oprand2_i : bus.oprand2_i;
                    rem_d  = '0;
                    cnt_d  = '0;
                    qneg_d = bus.signed_i && (bus.oprand1_i[31] ^ bus.oprand2_i[31]);
                    rneg_d = bus.signed_i && bus.oprand1_i[31];
                    state_d = (bus.oprand2_i == '0) ? S_DIVZERO : S_ON;
                end
            end
            S_DIVZERO: begin
                if (bus.cancel_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_END;
                    ready_d = 1'b1;
                end
            end
            S_ON: begin
                if (bus.cancel_i) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = rem_n;
                    quo_d = quo_n;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d  = S_END;
                        ready_d  = 1'b1;
                        result_d = {rneg_q ? -rem_n : rem_n, qneg_q ? -quo_n : quo_n};
                    end
                end
            end
            S_END: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign bus.result_o       = result_q;
    assign bus.ready_o        = ready_q;
    assign bus.pauseRequest_o = rst && !bus.cancel_i &&
                                (((state_q == S_IDLE) && bus.start_i) ||
                                 (state_q == S_DIVZERO) || (state_q == S_ON));
endmodule
